// File: rtl/uart_rx_bps.sv
// UART receiver (8N1 default, LSB first) driven by an external mid-bit baud tick generator.
// Define UART_RX_PARITY_EN to add a PARITY state, the PARITY_ODD parameter and the parity_err port.
module uart_rx_bps #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   bps_start_q, rx_valid_q, frame_err_q, rx_busy_q;
  logic                   rx_s, fall;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = rx_prev_q & ~rx_s;
  assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
  assign cnt_d   = cnt_q + 1'b1;

  assign bps_start = bps_start_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_bad_q, parity_err_q;
  assign parity_err = parity_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      rx_data_q    <= '0;
      bps_start_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (fall) begin
          state_q     <= S_START;
          bps_start_q <= 1'b1;
          rx_busy_q   <= 1'b1;
        end
        S_START: if (bps_clk) begin
          if (rx_s) begin
            // Line back high at mid start bit: treat as a glitch.
            state_q     <= S_IDLE;
            bps_start_q <= 1'b0;
            rx_busy_q   <= 1'b0;
          end else begin
            state_q <= S_DATA;
            cnt_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        S_DATA: if (bps_clk) begin
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
`ifdef UART_RX_PARITY_EN
          par_q   <= par_q ^ rx_s;
          if (cnt_q == CW'(DATA_BITS-1)) state_q <= S_PARITY;
`else
          if (cnt_q == CW'(DATA_BITS-1)) state_q <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (bps_clk) begin
          par_bad_q <= (par_q ^ rx_s) != PARITY_ODD;
          state_q   <= S_STOP;
        end
`endif
        S_STOP: if (bps_clk) begin
          bps_start_q <= 1'b0;
          if (rx_s) begin
            rx_data_q    <= shift_q;
            rx_valid_q   <= 1'b1;
            rx_busy_q    <= 1'b0;
            state_q      <= S_IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_bad_q;
`endif
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_BREAK;
          end
        end
        S_BREAK: if (rx_s) begin
          state_q   <= S_IDLE;
          rx_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          bps_start_q <= 1'b0;
          rx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_bps.sv
// Directed bench for uart_rx_bps with a 434/217 baud tick model at 50 MHz.
module tb_uart_rx_bps;
  localparam int BIT  = 434;
  localparam int HALF = 217;
  localparam bit PODD = 1'b0;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic       bps_clk, bps_start, rx_valid, frame_err, rx_busy;
  logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  uart_rx_bps #(
    .DATA_BITS(8), .SYNC_STAGES(2)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(PODD)
`endif
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .bps_clk(bps_clk), .bps_start(bps_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #10 clk = ~clk;

  // Baud generator model: counter cleared while bps_start is low, pulse at mid-bit.
  logic [8:0] bcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !bps_start)     bcnt <= '0;
    else if (bcnt == 9'(BIT-1)) bcnt <= '0;
    else                        bcnt <= bcnt + 9'd1;
  end
  assign bps_clk = bps_start && (bcnt == 9'(HALF));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvalid = 0, nferr = 0, nboth = 0, npe = 0, npe_vld = 0;
  int vcyc_last = 0, vcyc_prev = 0, t_start = 0;
  logic [7:0] vdat_last = 8'h00, vdat_prev = 8'h00;
  always @(negedge clk) begin
    if (rx_valid) begin
      nvalid++;
      vcyc_prev = vcyc_last; vcyc_last = cyc;
      vdat_prev = vdat_last; vdat_last = rx_data;
    end
    if (frame_err) nferr++;
    if (rx_valid && frame_err) nboth++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      npe++;
      if (rx_valid) npe_vld++;
    end
`endif
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT-1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT-1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PODD ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_v;
    int         exp_fe;
  } vec_t;

  vec_t tbl[6];
  int n0, f0;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    tbl[2] = '{8'h80, 1'b1, 8'h80, 1, 0};
    tbl[3] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    tbl[4] = '{8'hFF, 1'b0, 8'hA5, 0, 1};
    tbl[5] = '{8'h55, 1'b1, 8'h55, 1, 0};

    wait_clks(3);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(rx_busy), 0);
    chk("rst_bps_start", int'(bps_start), 0);
    rst = 1'b0;
    wait_clks(20);

    for (int i = 0; i < 6; i++) begin
      n0 = nvalid; f0 = nferr;
      send_frame(tbl[i].d, tbl[i].stop);
      @(negedge clk) rx = 1'b1;
      wait_clks(20);
      chk($sformatf("vec%0d_valid_cnt", i), nvalid - n0, tbl[i].exp_v);
      chk($sformatf("vec%0d_ferr_cnt", i), nferr - f0, tbl[i].exp_fe);
      chk($sformatf("vec%0d_data", i), int'(rx_data), int'(tbl[i].exp_data));
      chk($sformatf("vec%0d_bps_start", i), int'(bps_start), 0);
      chk($sformatf("vec%0d_busy", i), int'(rx_busy), 0);
      if (i == 0) chk("latency", (vcyc_last - t_start >= 4122 && vcyc_last - t_start <= 4132) ? 1 : 0, 1);
    end

    // Stop bit low, then line held low: BREAK until it returns high.
    n0 = nvalid; f0 = nferr;
    send_frame(8'hFF, 1'b0);
    wait_clks(2000);
    chk("brk_ferr_cnt", nferr - f0, 1);
    chk("brk_valid_cnt", nvalid - n0, 0);
    chk("brk_data_kept", int'(rx_data), 8'h55);
    chk("brk_busy", int'(rx_busy), 1);
    chk("brk_bps_start", int'(bps_start), 0);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    chk("brk_exit_busy", int'(rx_busy), 0);
    send_frame(8'h12, 1'b1);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    chk("after_brk_data", int'(rx_data), 8'h12);
    chk("after_brk_valid_cnt", nvalid - n0, 1);

    // Back-to-back frames, no idle between stop and next start.
    n0 = nvalid;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    chk("b2b_cnt", nvalid - n0, 2);
    chk("b2b_first", int'(vdat_prev), 8'hA3);
    chk("b2b_second", int'(vdat_last), 8'h3C);
    chk("b2b_gap", vcyc_last - vcyc_prev, 10*BIT);

    // 100-clk glitch: false start.
    n0 = nvalid; f0 = nferr;
    @(negedge clk) rx = 1'b0;
    wait_clks(50);
    chk("glitch_busy_mid", int'(rx_busy), 1);
    wait_clks(50);
    rx = 1'b1;
    wait_clks(400);
    chk("glitch_valid_cnt", nvalid - n0, 0);
    chk("glitch_ferr_cnt", nferr - f0, 0);
    chk("glitch_busy", int'(rx_busy), 0);
    chk("glitch_bps_start", int'(bps_start), 0);

    // Reset asserted during bit 4 of 0x81.
    n0 = nvalid; f0 = nferr;
    @(negedge clk) rx = 1'b0;
    repeat (BIT-1) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(((8'h81 >> i) & 8'h01) != 0);
    @(negedge clk) rx = 1'b0;
    wait_clks(200);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("mid_rst_data", int'(rx_data), 0);
    chk("mid_rst_bps_start", int'(bps_start), 0);
    chk("mid_rst_busy", int'(rx_busy), 0);
    chk("mid_rst_valid", int'(rx_valid), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    wait_clks(5);
    rst = 1'b0;
    wait_clks(50);
    chk("mid_rst_no_pulse", (nvalid - n0) + (nferr - f0), 0);
    send_frame(8'h7E, 1'b1);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    chk("after_rst_data", int'(rx_data), 8'h7E);
    chk("after_rst_valid_cnt", nvalid - n0, 1);

`ifdef UART_RX_PARITY_EN
    n0 = nvalid; f0 = npe;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    chk("par_ok_valid", nvalid - n0, 1);
    chk("par_ok_perr", npe - f0, 0);
    n0 = nvalid; f0 = npe_vld;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    @(negedge clk) rx = 1'b1;
    wait_clks(20);
    par_flip = 1'b0;
    chk("par_bad_valid", nvalid - n0, 1);
    chk("par_bad_perr_with_valid", npe_vld - f0, 1);
    chk("par_bad_data", int'(rx_data), 8'h07);
`endif

    chk("valid_ferr_exclusive", nboth, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
